// File: rtl/fifo_wr_arbiter.sv
// Packet-granular round-robin arbiter sharing one FIFO write port between NUM_REQ requesters.
// An owner that stays idle for TIMEOUT unstalled cycles is forcibly released.
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 18,
   parameter int TIMEOUT    = 255,
   parameter int CNT_WIDTH  = $clog2(TIMEOUT + 1)
) (
   input  logic                          i_Clk,
   input  logic                          i_Rst_n,
   input  logic [NUM_REQ-1:0]            i_Req,
   input  logic [NUM_REQ-1:0]            i_Last,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] i_Data,
   output logic [NUM_REQ-1:0]            o_Ack,
   output logic [NUM_REQ-1:0]            o_Grant,
   input  logic                          i_Fifo_Full,
   output logic                          o_Fifo_Data_Valid,
   output logic [DATA_WIDTH-1:0]         o_Fifo_Data,
   output logic                          o_Busy,
   output logic                          o_Timeout
);

   localparam int OWN_W = $clog2(NUM_REQ);
   localparam logic [OWN_W-1:0]     OWN_MAX  = OWN_W'(NUM_REQ - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);
   localparam logic [OWN_W:0]       REQ_NUM  = (OWN_W + 1)'(NUM_REQ);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t               state, state_nxt;
   logic [OWN_W-1:0]     ptr, ptr_nxt;
   logic [OWN_W-1:0]     owner, owner_nxt;
   logic [OWN_W-1:0]     owner_inc;
   logic [CNT_WIDTH-1:0] idle_cnt, idle_cnt_nxt;
   logic                 timeout_pulse, timeout_nxt;

   logic [DATA_WIDTH-1:0] words [NUM_REQ];
   logic [OWN_W-1:0]      pick;
   logic [OWN_W-1:0]      idx;
   logic [OWN_W:0]        sum;
   logic                  found;
   logic                  xfer;

   for (genvar k = 0; k < NUM_REQ; k++) begin : g_words
      assign words[k] = i_Data[k*DATA_WIDTH +: DATA_WIDTH];
   end

   // First requester at or after ptr, wrapping modulo NUM_REQ
   always_comb begin
      found = 1'b0;
      pick  = ptr;
      sum   = '0;
      idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         sum = {1'b0, ptr} + (OWN_W + 1)'(i);
         if (sum >= REQ_NUM) sum = sum - REQ_NUM;
         idx = sum[OWN_W-1:0];
         if (!found && i_Req[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   assign owner_inc         = (owner == OWN_MAX) ? '0 : owner + OWN_W'(1);
   assign o_Busy            = (state == LOCKED);
   assign o_Grant           = o_Busy ? (NUM_REQ'(1) << owner) : '0;
   assign o_Fifo_Data_Valid = o_Busy & i_Req[owner] & ~i_Fifo_Full;
   assign o_Ack             = o_Fifo_Data_Valid ? o_Grant : '0;
   assign o_Fifo_Data       = o_Busy ? words[owner] : '0;
   assign o_Timeout         = timeout_pulse;
   assign xfer              = o_Fifo_Data_Valid;

   always_comb begin
      state_nxt    = state;
      ptr_nxt      = ptr;
      owner_nxt    = owner;
      idle_cnt_nxt = idle_cnt;
      timeout_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (found) begin
               owner_nxt    = pick;
               idle_cnt_nxt = '0;
               state_nxt    = LOCKED;
            end
         end
         LOCKED: begin
            if (xfer) begin
               idle_cnt_nxt = '0;
               if (i_Last[owner]) begin
                  state_nxt = IDLE;
                  ptr_nxt   = owner_inc;
               end
            end else if (!i_Fifo_Full) begin
               // Owner is idle and the FIFO is not the cause of the stall
               if (idle_cnt == CNT_LAST) begin
                  state_nxt    = IDLE;
                  ptr_nxt      = owner_inc;
                  idle_cnt_nxt = '0;
                  timeout_nxt  = 1'b1;
               end else begin
                  idle_cnt_nxt = idle_cnt + CNT_WIDTH'(1);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state         <= IDLE;
         ptr           <= '0;
         owner         <= '0;
         idle_cnt      <= '0;
         timeout_pulse <= 1'b0;
      end else begin
         state         <= state_nxt;
         ptr           <= ptr_nxt;
         owner         <= owner_nxt;
         idle_cnt      <= idle_cnt_nxt;
         timeout_pulse <= timeout_nxt;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: packet ordering, round-robin rotation, full stalls,
// owner timeout and asynchronous reset.
module tb_fifo_wr_arbiter;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [3:0]       req;
   logic [3:0]       last;
   logic [3:0][17:0] data_arr;
   logic [3:0]       ack;
   logic [3:0]       grant;
   logic             full;
   logic             fvalid;
   logic [17:0]      fdata;
   logic             busy;
   logic             tout;

   int checks = 0;
   int errors = 0;
   int tout_cnt = 0;
   logic [17:0] fifo_q[$];

   fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(18), .TIMEOUT(255)) dut (
      .i_Clk(clk),
      .i_Rst_n(rst_n),
      .i_Req(req),
      .i_Last(last),
      .i_Data(data_arr),
      .o_Ack(ack),
      .o_Grant(grant),
      .i_Fifo_Full(full),
      .o_Fifo_Data_Valid(fvalid),
      .o_Fifo_Data(fdata),
      .o_Busy(busy),
      .o_Timeout(tout)
   );

   always #5 clk = ~clk;

   // Words presented at the negedge are the ones written at the following posedge
   always @(negedge clk) begin
      if (rst_n && fvalid) fifo_q.push_back(fdata);
      if (rst_n && tout) tout_cnt++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      req      = '0;
      last     = '0;
      full     = 1'b0;
      data_arr = '0;
      repeat (2) @(posedge clk);
      #1;
      fifo_q.delete();
      tout_cnt = 0;
      rst_n    = 1'b1;
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      req      = 4'b1111;
      last     = 4'b1111;
      full     = 1'b0;
      data_arr = '1;
      #3;
      checks++;
      if (grant !== 4'b0 || ack !== 4'b0) begin
         errors++;
         $display("FAIL reset_grant_ack: grant=%b ack=%b expected 0000/0000", grant, ack);
      end
      checks++;
      if (fvalid !== 1'b0 || fdata !== 18'h0) begin
         errors++;
         $display("FAIL reset_fifo_port: valid=%b data=%h expected 0/00000", fvalid, fdata);
      end
      checks++;
      if (busy !== 1'b0 || tout !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy_timeout: busy=%b timeout=%b expected 0/0", busy, tout);
      end
   endtask

   task automatic test_single_word();
      do_reset();
      req = 4'b0001; last = 4'b0001; data_arr[0] = 18'h00040;
      #1;
      checks++;
      if (grant !== 4'b0000 || fvalid !== 1'b0) begin
         errors++;
         $display("FAIL single_idle: grant=%b valid=%b expected 0000/0", grant, fvalid);
      end
      step();
      checks++;
      if (grant !== 4'b0001 || ack !== 4'b0001 || fvalid !== 1'b1 || fdata !== 18'h00040) begin
         errors++;
         $display("FAIL single_grant: grant=%b ack=%b valid=%b data=%h expected 0001/0001/1/00040",
                  grant, ack, fvalid, fdata);
      end
      step();
      req = 4'b0011; last = 4'b0011; data_arr[1] = 18'h00041;
      #1;
      checks++;
      if (busy !== 1'b0 || fifo_q.size() != 1 || fifo_q[0] !== 18'h00040) begin
         errors++;
         $display("FAIL single_written: busy=%b fifo_words=%0d first=%h expected 0/1/00040",
                  busy, fifo_q.size(), fifo_q[0]);
      end
      step();
      checks++;
      if (grant !== 4'b0010 || fdata !== 18'h00041) begin
         errors++;
         $display("FAIL single_ptr_advance: grant=%b data=%h expected 0010/00041", grant, fdata);
      end
   endtask

   task automatic test_multi_word();
      do_reset();
      req = 4'b0001; last = 4'b0000; data_arr[0] = 18'h0008C; data_arr[2] = 18'h00111;
      step();
      req = 4'b0101; last = 4'b0100;
      #1;
      checks++;
      if (ack !== 4'b0001 || fdata !== 18'h0008C) begin
         errors++;
         $display("FAIL multi_word1: ack=%b data=%h expected 0001/0008c", ack, fdata);
      end
      step();
      data_arr[0] = 18'h000C0;
      #1;
      checks++;
      if (ack !== 4'b0001 || fdata !== 18'h000C0) begin
         errors++;
         $display("FAIL multi_word2: ack=%b data=%h expected 0001/000c0", ack, fdata);
      end
      step();
      data_arr[0] = 18'h000FF; last = 4'b0101;
      #1;
      checks++;
      if (ack !== 4'b0001 || grant !== 4'b0001) begin
         errors++;
         $display("FAIL multi_word3: ack=%b grant=%b expected 0001/0001", ack, grant);
      end
      step();
      req = 4'b0100;
      #1;
      checks++;
      if (grant !== 4'b0000 || busy !== 1'b0) begin
         errors++;
         $display("FAIL multi_gap: grant=%b busy=%b expected 0000/0", grant, busy);
      end
      step();
      checks++;
      if (grant !== 4'b0100 || ack !== 4'b0100 || fdata !== 18'h00111) begin
         errors++;
         $display("FAIL multi_next_owner: grant=%b ack=%b data=%h expected 0100/0100/00111",
                  grant, ack, fdata);
      end
      step();
      req = 4'b0000;
      #1;
      checks++;
      if (fifo_q.size() != 4 || fifo_q[0] !== 18'h0008C || fifo_q[1] !== 18'h000C0 ||
          fifo_q[2] !== 18'h000FF || fifo_q[3] !== 18'h00111) begin
         errors++;
         $display("FAIL multi_order: words=%0d got %h %h %h %h expected 0008c 000c0 000ff 00111",
                  fifo_q.size(), fifo_q[0], fifo_q[1], fifo_q[2], fifo_q[3]);
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_ack;
      do_reset();
      req = 4'b1111; last = 4'b1111;
      for (int k = 0; k < 4; k++) data_arr[k] = 18'(18'h00100 + k);
      for (int c = 0; c <= 16; c++) begin
         if (c > 0) step();
         #1;
         exp_ack = (c % 2 == 1) ? (4'b0001 << (((c - 1) / 2) % 4)) : 4'b0000;
         checks++;
         if (ack !== exp_ack || grant !== exp_ack) begin
            errors++;
            $display("FAIL rr_cycle%0d: ack=%b grant=%b expected %b", c, ack, grant, exp_ack);
         end
      end
      req = 4'b0000;
      step();
   endtask

   task automatic test_full_stall();
      int bad;
      do_reset();
      req = 4'b0001; last = 4'b0000; data_arr[0] = 18'h000A1;
      step();
      step();
      data_arr[0] = 18'h000A2; last = 4'b0001; full = 1'b1;
      #1;
      checks++;
      if (ack !== 4'b0000 || fvalid !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL full_block: ack=%b valid=%b busy=%b expected 0000/0/1", ack, fvalid, busy);
      end
      bad = 0;
      for (int c = 0; c < 300; c++) begin
         step();
         #1;
         if (ack !== 4'b0000 || tout !== 1'b0 || grant !== 4'b0001) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL full_hold: bad_cycles=%0d expected 0", bad);
      end
      step();
      full = 1'b0;
      #1;
      checks++;
      if (fvalid !== 1'b1 || ack !== 4'b0001 || fdata !== 18'h000A2) begin
         errors++;
         $display("FAIL full_release: valid=%b ack=%b data=%h expected 1/0001/000a2",
                  fvalid, ack, fdata);
      end
      step();
      req = 4'b0000;
      #1;
      checks++;
      if (fifo_q.size() != 2 || fifo_q[1] !== 18'h000A2 || tout_cnt != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL full_result: words=%0d second=%h timeouts=%0d busy=%b expected 2/000a2/0/0",
                  fifo_q.size(), fifo_q[1], tout_cnt, busy);
      end
   endtask

   task automatic test_timeout();
      int n;
      do_reset();
      req = 4'b0010; last = 4'b0000; data_arr[1] = 18'h00055; data_arr[2] = 18'h00077;
      step();
      step();
      req = 4'b0100; last = 4'b0110;
      #1;
      checks++;
      if (tout !== 1'b0 || busy !== 1'b1 || ack !== 4'b0000) begin
         errors++;
         $display("FAIL timeout_start: timeout=%b busy=%b ack=%b expected 0/1/0000", tout, busy, ack);
      end
      n = 0;
      while (tout !== 1'b1 && n < 400) begin
         step();
         #1;
         n++;
      end
      checks++;
      if (n != 255) begin
         errors++;
         $display("FAIL timeout_latency: cycles=%0d expected 255", n);
      end
      checks++;
      if (busy !== 1'b0 || grant !== 4'b0000 || fifo_q.size() != 1) begin
         errors++;
         $display("FAIL timeout_release: busy=%b grant=%b words=%0d expected 0/0000/1",
                  busy, grant, fifo_q.size());
      end
      step();
      checks++;
      if (tout !== 1'b0 || grant !== 4'b0100 || ack !== 4'b0100 || fdata !== 18'h00077) begin
         errors++;
         $display("FAIL timeout_next: timeout=%b grant=%b ack=%b data=%h expected 0/0100/0100/00077",
                  tout, grant, ack, fdata);
      end
      step();
      req = 4'b0000;
      #1;
      checks++;
      if (tout_cnt != 1) begin
         errors++;
         $display("FAIL timeout_pulses: count=%0d expected 1", tout_cnt);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      req = 4'b0001; last = 4'b0001; data_arr[0] = 18'h0003C; data_arr[1] = 18'h0005A;
      step();
      step();
      req = 4'b0010; last = 4'b0000;
      step();
      checks++;
      if (fvalid !== 1'b1 || grant !== 4'b0010) begin
         errors++;
         $display("FAIL areset_pre: valid=%b grant=%b expected 1/0010", fvalid, grant);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (fvalid !== 1'b0 || grant !== 4'b0000 || busy !== 1'b0) begin
         errors++;
         $display("FAIL areset_immediate: valid=%b grant=%b busy=%b expected 0/0000/0",
                  fvalid, grant, busy);
      end
      step();
      rst_n = 1'b1;
      req = 4'b0011; last = 4'b0011;
      step();
      checks++;
      if (grant !== 4'b0001 || fdata !== 18'h0003C) begin
         errors++;
         $display("FAIL areset_restart: grant=%b data=%h expected 0001/0003c", grant, fdata);
      end
      req = 4'b0000;
      step();
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_multi_word();
      test_round_robin();
      test_full_stall();
      test_timeout();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Shares the single write port of the display command FIFO (18-bit entries) between NUM_REQ requesters, such as the key-scan responder, the LED/segment updater and the brightness controller.
- Round-robin arbitration at packet granularity: once granted, a requester owns the port until it writes a word flagged last. This keeps multi-word TM1638 command sequences contiguous in the FIFO.
- A stalled owner is evicted after a timeout.
- Sits between the requesters and the FIFO's i_Data_Valid/i_Data/o_Full port.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
DATA_WIDTH, 18, FIFO word width.
TIMEOUT, 255, consecutive owner-idle cycles before forced release (1..65535).
CNT_WIDTH, $clog2(TIMEOUT+1), width of the idle counter.

Ports:
i_Clk  in  1  system clock.
i_Rst_n  in  1  asynchronous active-low reset.
i_Req  in  NUM_REQ  per-requester word-valid; requester k presents data while high.
i_Last  in  NUM_REQ  per-requester end-of-packet flag, qualified by i_Req[k].
i_Data  in  NUM_REQ*DATA_WIDTH  requester k word in bits [k*DATA_WIDTH +: DATA_WIDTH].
o_Ack  out  NUM_REQ  one-hot; high in the cycle the owner's word is written at the next posedge.
o_Grant  out  NUM_REQ  one-hot ownership indication (registered).
i_Fifo_Full  in  1  FIFO o_Full.
o_Fifo_Data_Valid  out  1  to FIFO i_Data_Valid.
o_Fifo_Data  out  DATA_WIDTH  to FIFO i_Data.
o_Busy  out  1  high while in LOCKED.
o_Timeout  out  1  single-cycle pulse on forced release.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, r_Ptr=0, r_Owner=0, idle counter=0.
  - o_Grant=0, o_Ack=0, o_Fifo_Data_Valid=0, o_Fifo_Data=0, o_Busy=0, o_Timeout=0.
  - Reset mid-packet abandons the packet; words already written stay in the FIFO.
- IDLE:
  - No grant; o_Fifo_Data_Valid=0.
  - If any i_Req is high, select the first requesting index scanning r_Ptr, r_Ptr+1, ... mod NUM_REQ.
  - Register it as r_Owner and go to LOCKED at the next posedge.
  - Request-to-grant latency is 1 cycle.
- LOCKED:
  - o_Grant = onehot(r_Owner); o_Busy=1.
  - o_Fifo_Data = i_Data slice of r_Owner. When the FIFO port is not valid, o_Fifo_Data is don't-care.
  - o_Fifo_Data_Valid = i_Req[r_Owner] & ~i_Fifo_Full, combinational.
  - o_Ack[r_Owner] = o_Fifo_Data_Valid; other o_Ack bits are 0.
  - A word is transferred at each posedge where o_Fifo_Data_Valid=1. Back-to-back words are allowed every cycle.
- Packet end: a transfer with i_Last[r_Owner]=1 moves to IDLE and sets r_Ptr = (r_Owner+1) mod NUM_REQ.
  - The minimum gap between packets is 1 IDLE cycle.
  - A single-word packet takes 2 cycles from request to FIFO write.
- Timeout:
  - The idle counter clears on every transfer and holds while i_Fifo_Full=1, because that stall is not the owner's fault.
  - Otherwise it increments each LOCKED cycle with i_Req[r_Owner]=0.
  - When it reaches TIMEOUT: go to IDLE, pulse o_Timeout for 1 cycle, set r_Ptr = r_Owner+1, clear the counter.
- Non-owner requests are ignored while LOCKED; they stay pending and receive no ack.
- Full:
  - No write and no ack while i_Fifo_Full=1.
  - The owner keeps i_Req/i_Data stable until acked.
  - Deassertion of full resumes transfer in the same cycle.
- i_Last without i_Req is ignored.
- A request arriving in the same cycle as the packet-end transfer is arbitrated in the following IDLE cycle.
- Round-robin fairness: with all requesters continuously requesting, grants rotate 0,1,2,3,0,...
- Requester ready contract: a word is consumed only when o_Ack[k]=1.

Test Plan:
- Reset, then i_Req=0001 with a 1-word packet (data 18'h00040, last=1) → o_Grant=0001 after 1 cycle; FIFO receives 18'h00040; back to IDLE; r_Ptr=1.
- Req 0 sends a 3-word packet (18'h0008C, 18'h000C0, 18'h000FF, last on the 3rd) while req 2 requests from cycle 1 → FIFO order is 8C, C0, FF, then req 2's words; no interleaving.
- All four requesting 1-word packets continuously → grant sequence 0,1,2,3,0; each requester gets an ack every 8 cycles.
- Owner mid-packet with i_Fifo_Full=1 for 300 cycles → no acks, no timeout; first word written in the cycle full drops.
- Owner (req 1) drops i_Req mid-packet with TIMEOUT=255 → o_Timeout pulses exactly 255 cycles later; next grant goes to req 2 if requesting.
- Assert i_Rst_n=0 asynchronously mid-packet → o_Fifo_Data_Valid and o_Grant go low without a clock edge; after release, arbitration restarts from r_Ptr=0.
